// File: rtl/fibo_datapath.sv
// Fibonacci calculator datapath: 4-entry register file, 3-bit ALU, zero flag and result capture.
// Optional macro FIBO_SAT_EN: saturating ADD plus sticky overflow flag (ovf tied low otherwise).
module fibo_datapath #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] data_in,
  input  logic         load_data,
  input  logic         wrt_en,
  input  logic [1:0]   wrt_addr,
  input  logic [1:0]   rd_addr1,
  input  logic [1:0]   rd_addr2,
  input  logic [2:0]   alu_opcode,
  input  logic         done,
  output logic         zero_flag,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         ovf
);

  logic [W-1:0] rf_reg [4];
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] alu_y;
  logic [W-1:0] wr_data;
  logic [3:0]   wr_sel;
  logic         zero_flag_reg;
  logic [W-1:0] result_reg;
  logic         result_valid_reg;

  assign op_a = rf_reg[rd_addr1];
  assign op_b = rf_reg[rd_addr2];

`ifdef FIBO_SAT_EN
  logic [W:0] add_ext;
  logic       add_carry;
  assign add_ext   = {1'b0, op_a} + {1'b0, op_b};
  assign add_carry = add_ext[W];
`endif

  always_comb begin
    alu_y = '0;
    case (alu_opcode)
      3'b000: alu_y = op_a;
`ifdef FIBO_SAT_EN
      3'b001: alu_y = add_carry ? {W{1'b1}} : add_ext[W-1:0];
`else
      3'b001: alu_y = op_a + op_b;
`endif
      3'b010: alu_y = op_a - op_b;
      3'b011: alu_y = op_a - 1'b1;
      3'b100: alu_y = op_a + 1'b1;
      3'b101: alu_y = op_a & op_b;
      3'b110: alu_y = op_a | op_b;
      3'b111: alu_y = '0;
      default: alu_y = '0;
    endcase
  end

  assign wr_data = load_data ? data_in : alu_y;

  // One-hot write decode; reads see the pre-edge contents, so read-during-write returns old data.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wrt_en && (wrt_addr == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_sel[i]) rf_reg[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_flag_reg    <= 1'b0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
    end else begin
      if (wrt_en) zero_flag_reg <= (wr_data == '0);
      // done has priority over start so a coincident pair still delivers a result
      if (done) begin
        result_reg       <= op_a;
        result_valid_reg <= 1'b1;
      end else if (start) begin
        result_valid_reg <= 1'b0;
      end
    end
  end

`ifdef FIBO_SAT_EN
  logic ovf_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else begin
      if (start && !done) ovf_reg <= 1'b0;
      if (wrt_en && !load_data && (alu_opcode == 3'b001) && add_carry) ovf_reg <= 1'b1;
    end
  end
  assign ovf = ovf_reg;
`else
  assign ovf = 1'b0;
`endif

  assign zero_flag    = zero_flag_reg;
  assign result       = result_reg;
  assign result_valid = result_valid_reg;

endmodule

// File: tb/tb_fibo_datapath.sv
// Self-checking bench for fibo_datapath: directed scenarios plus randomized traffic,
// checked every cycle against an arithmetic model of the register file and status outputs.
module tb_fibo_datapath;
  localparam int W = 8;
  localparam int unsigned MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         load_data = 1'b0;
  logic         wrt_en = 1'b0;
  logic [1:0]   wrt_addr = '0;
  logic [1:0]   rd_addr1 = '0;
  logic [1:0]   rd_addr2 = '0;
  logic [2:0]   alu_opcode = '0;
  logic         done = 1'b0;
  logic         zero_flag;
  logic [W-1:0] result;
  logic         result_valid;
  logic         ovf;

  fibo_datapath #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .load_data(load_data),
    .wrt_en(wrt_en), .wrt_addr(wrt_addr), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .alu_opcode(alu_opcode), .done(done), .zero_flag(zero_flag), .result(result),
    .result_valid(result_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  int unsigned m_rf [4];
  bit          m_zf;
  bit          m_rv;
  bit          m_ovf;
  int unsigned m_res;

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int unsigned model_alu(input int op, input int unsigned a, input int unsigned b);
    int unsigned s;
    case (op)
      0: return a;
      1: begin
        s = a + b;
`ifdef FIBO_SAT_EN
        if (s > MASK) return MASK;
`endif
        return s & MASK;
      end
      2: return (a - b) & MASK;
      3: return (a - 1) & MASK;
      4: return (a + 1) & MASK;
      5: return a & b;
      6: return a | b;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 0;
    m_zf = 0; m_rv = 0; m_ovf = 0; m_res = 0;
  endtask

  // Applies one clock edge of the architectural rules to the model, using pre-edge values.
  task automatic model_step();
    int unsigned a, b, wv;
    a  = m_rf[rd_addr1];
    b  = m_rf[rd_addr2];
    wv = load_data ? int'(data_in) : model_alu(int'(alu_opcode), a, b);
    if (done) begin
      m_res = a; m_rv = 1;
    end else if (start) begin
      m_rv = 0;
    end
`ifdef FIBO_SAT_EN
    if (start && !done) m_ovf = 0;
    if (wrt_en && !load_data && alu_opcode == 3'b001 && (a + b) > MASK) m_ovf = 1;
`endif
    if (wrt_en) begin
      m_rf[wrt_addr] = wv;
      m_zf = (wv == 0);
    end
  endtask

  task automatic drive(input bit we, input bit ld, input int wa, input int r1, input int r2,
                       input int op, input int din, input bit st, input bit dn);
    wrt_en = we; load_data = ld; wrt_addr = 2'(wa); rd_addr1 = 2'(r1); rd_addr2 = 2'(r2);
    alu_opcode = 3'(op); data_in = W'(din); start = st; done = dn;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    cyc++;
    $display("cyc %0d we=%0d ld=%0d wa=%0d r1=%0d r2=%0d op=%0d din=%0d st=%0d dn=%0d | zf=%0d res=%0d rv=%0d ovf=%0d",
             cyc, wrt_en, load_data, wrt_addr, rd_addr1, rd_addr2, alu_opcode, data_in,
             start, done, zero_flag, result, result_valid, ovf);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("zero_flag", zero_flag, m_zf);
      check("result", result, m_res);
      check("result_valid", result_valid, m_rv);
      check("ovf", ovf, m_ovf);
    end
  end

  initial begin
    model_reset();
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_result", result, 0);
    check("reset_valid", result_valid, 0);

    // Mid-stream reset: load rf[2]=9, capture it, then reset asynchronously.
    drive(1, 1, 2, 0, 0, 0, 9, 0, 0); tick();
    drive(0, 0, 0, 2, 0, 0, 0, 0, 1); tick();
    check("pre_reset_result", result, 9);
    drive(1, 1, 2, 0, 0, 0, 77, 0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_result", result, 0);
    check("async_rst_valid", result_valid, 0);
    check("async_rst_zf", zero_flag, 0);
    check("async_rst_ovf", ovf, 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 2, 0, 0, 0, 0, 1); tick();
    check("rf2_after_reset", result, 0);

    // Load / decrement to zero
    drive(1, 1, 0, 0, 0, 0, 7, 0, 0); tick();
    check("load7_zf", zero_flag, 0);
    for (int k = 1; k <= 7; k++) begin
      drive(1, 0, 0, 0, 0, 3, 0, 0, 0); tick();
      check("dec_zf", zero_flag, (k == 7) ? 1 : 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    check("dec_result", result, 0);

    // Fibonacci: rf1=F(k-1), rf2=F(k); nine steps take rf2 from F(1) to F(10)=55
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 2, 0, 0, 0, 1, 0, 0); tick();
    for (int k = 0; k < 9; k++) begin
      drive(1, 0, 3, 1, 2, 1, 0, 0, 0); tick();
      drive(1, 0, 1, 2, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 2, 3, 0, 0, 0, 0, 0); tick();
    end
    drive(0, 0, 0, 2, 0, 0, 0, 0, 1); tick();
    check("fib10_result", result, 55);
    check("fib10_valid", result_valid, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    check("start_clears_valid", result_valid, 0);
    check("start_keeps_result", result, 55);

    // Read-during-write hazard on the capture path
    drive(1, 1, 1, 0, 0, 0, 3, 0, 0); tick();
    drive(1, 1, 1, 1, 0, 0, 5, 0, 1); tick();
    check("hazard_old_value", result, 3);
    drive(0, 0, 0, 1, 0, 0, 0, 1, 1); tick();
    check("hazard_new_value", result, 5);
    check("start_done_valid", result_valid, 1);

    // Overflow: 233 + 144 = 377
    drive(1, 1, 0, 0, 0, 0, 233, 0, 0); tick();
    drive(1, 1, 1, 0, 0, 0, 144, 0, 0); tick();
    drive(1, 0, 2, 0, 1, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 2, 0, 0, 0, 0, 1); tick();
`ifdef FIBO_SAT_EN
    check("ovf_add_value", result, 255);
    check("ovf_set", ovf, 1);
    idle(); tick();
    check("ovf_held", ovf, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    check("ovf_cleared_by_start", ovf, 0);
`else
    check("ovf_add_value", result, 121);
    check("ovf_tied_low", ovf, 0);
`endif

    // Randomized traffic; start is kept away from ADD writes so ovf clear/set never coincide.
    for (int n = 0; n < 400; n++) begin
      int op;
      bit st;
      bit we;
      op = $urandom_range(0, 7);
      st = ($urandom_range(0, 9) == 0);
      we = ($urandom_range(0, 3) != 0);
      if (st && we && op == 1) op = 0;
      drive(we, $urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), op, $urandom_range(0, 255), st, $urandom_range(0, 5) == 0);
      tick();
    end

    idle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fibo_datapath.md
Name: fibo_datapath

Overview:
- Datapath end of the Fibonacci calculator. Executes the control word issued by the Fibonacci controller FSM each cycle.
- Contains a 4-entry register file (2 async read ports, 1 sync write port), a 3-bit-opcode ALU and a registered zero flag that is returned to the FSM.
- Captures the final result when the FSM raises done, and holds it for the top level.

Parameters:
- W, 8, data/register width in bits (min 4).

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  asynchronous, active-high reset
- start  in  1  new-run request (same signal the FSM sees); clears result_valid
- data_in  in  W  operand N, written when load_data=1
- load_data  in  1  write-data mux select: 1 = data_in, 0 = ALU result
- wrt_en  in  1  register-file write enable
- wrt_addr  in  2  write address
- rd_addr1  in  2  read address, ALU operand A
- rd_addr2  in  2  read address, ALU operand B
- alu_opcode  in  3  ALU operation
- done  in  1  FSM completion strobe
- zero_flag  out  1  registered zero status of the last written value
- result  out  W  captured Fibonacci result
- result_valid  out  1  result holds a completed run
- ovf  out  1  sticky ADD overflow (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - rf[0..3]=0, zero_flag=0, result=0, result_valid=0, ovf=0.
  - rst asserted mid-run aborts the run immediately. No write completes on the edge on which rst is high.
- Reads are combinational: A=rf[rd_addr1], B=rf[rd_addr2].
- Read-during-write to the same address returns the old value. The new value is visible the cycle after the edge.
- ALU (combinational, W-bit, modulo 2^W unless FIBO_SAT_EN):
  - 000 Y=A
  - 001 Y=A+B
  - 010 Y=A-B
  - 011 Y=A-1
  - 100 Y=A+1
  - 101 Y=A&B
  - 110 Y=A|B
  - 111 Y=0
- Write, at rising clk with wrt_en=1:
  - rf[wrt_addr] <= load_data ? data_in : Y.
  - load_data with wrt_en=0 has no effect.
- zero_flag:
  - Updated only on a write edge: zero_flag <= (written value == 0). Latency is 1 cycle after the write.
  - Holds its value when wrt_en=0.
- Result capture:
  - At rising clk with done=1: result <= rf[rd_addr1] (pre-write value if a same-cycle write targets rd_addr1), and result_valid <= 1.
  - At rising clk with start=1 and done=0: result_valid <= 0; result holds its value.
  - start and done in the same cycle: done wins (capture, valid=1).
  - done repeated: recapture on every done edge.
- ovf:
  - Set on a write edge where opcode=001, load_data=0 and A+B carries out of bit W-1.
  - Cleared only by reset or by a start edge (start=1, done=0).
- Sequential elements are limited to: rf, zero_flag, result, result_valid, ovf.

Optional Feature:
- Macro: FIBO_SAT_EN.
- Defined:
  - ADD (001) saturates to all-ones (2^W-1) on carry-out; the saturated value is written.
  - ovf is set as above.
- Undefined:
  - ADD wraps modulo 2^W.
  - ovf is tied to constant 0.
- All other opcodes are unaffected in both cases.

Test Plan:
- Reset: assert rst mid-stream after loading rf[2]=9 -> all rf read 0, zero_flag=0, result=0, result_valid=0, ovf=0 asynchronously, before the next clk edge.
- Load/flag: load_data=1, wrt_en=1, wrt_addr=0, data_in=7 -> rf[0]=7 next cycle, zero_flag=0. Then opcode 011 with rd1=0, wr=0, repeated 7 times -> rf[0] steps 6..0, and zero_flag=1 exactly one cycle after the 7th write.
- Fibonacci run (W=8): rf[1]=0, rf[2]=1, iterate ADD into rf[3] with 1<-2, 2<-3 moves via opcode 000 for N=10 -> done with rd_addr1=2 gives result=55, result_valid=1. A following start clears result_valid while result stays 55.
- Hazards: same-cycle write rf[1]=5 with rd_addr1=1, done=1 (old rf[1]=3) -> result=3, rf[1]=5 next cycle. start+done together -> result_valid=1.
- Overflow, undefined FIBO_SAT_EN: A=233, B=144, ADD -> write 121, ovf=0.
- Overflow, defined FIBO_SAT_EN: same operands -> write 255, ovf=1, held until start, then 0.
